// File: rtl/systolic_array_param.sv
// -----------------------------------------------------------------------------
// systolic_array_param
// Output-stationary N x N systolic matrix multiplier, C = A x B, where A is
// N x K and B is K x N. K is supplied at runtime with each start.
// The feeder presents one unskewed column of A and one row of B per beat. The
// block skews them internally, so PE(i,j) accumulates a beat accepted at edge e
// at edge e+1+i+j.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     begin a new product (sampled only in IDLE)
//   k_len     inner dimension K, latched at an accepted start
//   in_valid  a_col/b_row beat valid
//   in_ready  a beat is accepted this cycle when in_valid is also high
//   a_col     A[i][k], lane i at bits [i*DATA_W +: DATA_W]
//   b_row     B[k][j], lane j at bits [j*DATA_W +: DATA_W]
//   busy      high in every state except IDLE
//   done      one-cycle pulse; results in out are final
//   out       C[i][j], p=i*N+j, p=0 at the MSBs
// -----------------------------------------------------------------------------
module systolic_array_param #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int KLEN_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KLEN_W-1:0]         k_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*DATA_W-1:0]       a_col,
  input  logic [N*DATA_W-1:0]       b_row,
  output logic                      busy,
  output logic                      done,
  output logic [N*N*ACC_W-1:0]      out
);

  // The last PE accumulates 2N-1 edges after the last accepting edge.
  localparam int DRN_W = $clog2(2 * N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [KLEN_W-1:0]   r_k;
  logic [KLEN_W-1:0]   r_beat;
  logic [DRN_W-1:0]    r_drain;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_done;

  logic                w_accept;
  logic                w_clr;

  // Operand tokens {valid, data}. w_a[i][j] is the A input of PE(i,j) and
  // w_b[i][j] is the B input of PE(i,j).
  logic [N-1:0][N-1:0][DATA_W:0] w_a;
  logic [N-1:0][N-1:0][DATA_W:0] w_b;

  assign w_accept = in_valid & r_in_ready;
  // Accumulators are cleared on any start accepted from IDLE, including K=0.
  assign w_clr    = (r_state == ST_IDLE) & start;

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;

  // Controller: sequences IDLE -> LOAD -> DRAIN -> DONE with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_beat     <= '0;
      r_drain    <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy  <= 1'b1;
            r_beat  <= '0;
            r_drain <= '0;
            if (k_len != '0) begin
              r_k        <= k_len;
              r_in_ready <= 1'b1;
              r_state    <= ST_LOAD;
            end else begin
              // Empty product: nothing to load, report an all-zero result.
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            if (r_beat == r_k - KLEN_W'(1)) begin
              r_in_ready <= 1'b0;
              r_drain    <= '0;
              r_state    <= ST_DRAIN;
            end else begin
              r_beat <= r_beat + KLEN_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // Bubbles only precede the last beat, so the drain length is fixed.
          if (r_drain == DRN_W'(2 * N - 2)) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_drain <= r_drain + DRN_W'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  genvar gi, gj;

  // Input skew: lane i passes through i+1 registers (capture stage plus i delays).
  for (gi = 0; gi < N; gi++) begin : g_skew
    logic [DATA_W:0] r_a_sk [gi+1];
    logic [DATA_W:0] r_b_sk [gi+1];

    // Shift each lane's {valid, data} token one stage per cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s <= gi; s++) begin
          r_a_sk[s] <= '0;
          r_b_sk[s] <= '0;
        end
      end else begin
        r_a_sk[0] <= {w_accept, a_col[gi*DATA_W +: DATA_W]};
        r_b_sk[0] <= {w_accept, b_row[gi*DATA_W +: DATA_W]};
        for (int s = 1; s <= gi; s++) begin
          r_a_sk[s] <= r_a_sk[s-1];
          r_b_sk[s] <= r_b_sk[s-1];
        end
      end
    end

    assign w_a[gi][0] = r_a_sk[gi];
    assign w_b[0][gi] = r_b_sk[gi];
  end

  // PE mesh.
  for (gi = 0; gi < N; gi++) begin : g_row
    for (gj = 0; gj < N; gj++) begin : g_col
      logic signed [ACC_W-1:0]    r_acc;
      logic signed [2*DATA_W-1:0] w_prod;
      logic signed [ACC_W-1:0]    w_prod_x;
      logic                       w_fire;

      assign w_fire   = w_a[gi][gj][DATA_W] & w_b[gi][gj][DATA_W];
      assign w_prod   = $signed(w_a[gi][gj][DATA_W-1:0]) * $signed(w_b[gi][gj][DATA_W-1:0]);
      // Signed cast sign-extends the full product to accumulator width.
      assign w_prod_x = ACC_W'(w_prod);

      // Accumulate valid products; the sum wraps modulo 2^ACC_W.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_acc <= '0;
        end else if (w_clr) begin
          r_acc <= '0;
        end else if (w_fire) begin
          r_acc <= r_acc + w_prod_x;
        end
      end

      assign out[(N*N - (gi*N + gj))*ACC_W - 1 -: ACC_W] = r_acc;

      // The last column has no east neighbour, so it has no A pass register.
      if (gj < N - 1) begin : g_east
        logic [DATA_W:0] r_a_q;
        // Pass operand A eastward.
        always_ff @(posedge clk) begin
          if (rst) begin
            r_a_q <= '0;
          end else begin
            r_a_q <= w_a[gi][gj];
          end
        end
        assign w_a[gi][gj+1] = r_a_q;
      end

      // The bottom row has no south neighbour, so it has no B pass register.
      if (gi < N - 1) begin : g_south
        logic [DATA_W:0] r_b_q;
        // Pass operand B southward.
        always_ff @(posedge clk) begin
          if (rst) begin
            r_b_q <= '0;
          end else begin
            r_b_q <= w_b[gi][gj];
          end
        end
        assign w_b[gi+1][gj] = r_b_q;
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_param.sv
// -----------------------------------------------------------------------------
// tb_systolic_array_param
// Directed self-checking bench for systolic_array_param (N=4, 16-bit operands,
// 32-bit results). Expected values are hand-derived constants per test.
// -----------------------------------------------------------------------------
module tb_systolic_array_param;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int KW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   a_col;
  logic [N*DW-1:0]   b_row;
  logic              busy;
  logic              done;
  logic [N*N*AW-1:0] out;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ma    [N][N];   // A[i][k]
  logic [DW-1:0] mb    [N][N];   // B[k][j]
  logic [AW-1:0] exp_c [N][N];

  systolic_array_param #(.N(N), .DATA_W(DW), .ACC_W(AW), .KLEN_W(KW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_col    (a_col),
    .b_row    (b_row),
    .busy     (busy),
    .done     (done),
    .out      (out)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; all driving and sampling happens 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] get_c(input int i, input int j);
    return out[(N*N - (i*N + j))*AW - 1 -: AW];
  endfunction

  task automatic fill(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic [AW-1:0] cv);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j]    = av;
        mb[i][j]    = bv;
        exp_c[i][j] = cv;
      end
    end
  endtask

  task automatic launch(input string tag, input int k, input bit hold);
    start = 1'b1;
    k_len = KW'(k);
    tick();
    if (!hold) start = 1'b0;
    check_val({tag, "_busy_start"}, busy, 1);
    check_val({tag, "_ready_start"}, in_ready, (k != 0));
    check_val({tag, "_done_start"}, done, (k == 0));
  endtask

  // Feed K beats (optional bubble after beat bub_after), then check latency and results.
  task automatic feed(input string tag, input int k, input int bub_after, input int bub_len);
    int n;
    for (int b = 0; b < k; b++) begin
      in_valid = 1'b1;
      for (int l = 0; l < N; l++) begin
        a_col[l*DW +: DW] = ma[l][b];
        b_row[l*DW +: DW] = mb[b][l];
      end
      tick();
      check_val({tag, "_ready_after_beat"}, in_ready, (b < k - 1));
      if (b == bub_after) begin
        in_valid = 1'b0;
        a_col    = {N{16'h1234}};
        b_row    = {N{16'h4321}};
        for (int c = 0; c < bub_len; c++) begin
          tick();
          check_val({tag, "_ready_bubble"}, in_ready, 1);
          check_val({tag, "_done_bubble"}, done, 0);
        end
      end
    end
    in_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      check_val({tag, "_busy_drain"}, busy, 1);
    end while (!done && n < 40);
    check_val({tag, "_latency"}, n, 7);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        check_val($sformatf("%s_c%0d%0d", tag, i, j), get_c(i, j), exp_c[i][j]);
      end
    end
    tick();
    check_val({tag, "_done_pulse"}, done, 0);
    check_val({tag, "_busy_end"}, busy, 0);
  endtask

  // Safety net: never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b0;
    a_col    = '0;
    b_row    = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ready", in_ready, 0);
    check_val("rst_out", |out, 0);

    // Identity A, B[k][j]=16k+j -> C[i][j]=16i+j.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j]    = (i == j) ? 16'd1 : 16'd0;
        mb[i][j]    = DW'(16 * i + j);
        exp_c[i][j] = AW'(16 * i + j);
      end
    end
    launch("ident", 4, 1'b0);
    feed("ident", 4, -1, 0);

    // A=-2, B=3, K=3, two-cycle bubble after beat 1 -> -18.
    fill(16'hFFFE, 16'h0003, 32'hFFFF_FFEE);
    launch("bubble", 3, 1'b0);
    feed("bubble", 3, 1, 2);

    // 4 * 0x7FFF^2 wraps without saturation.
    fill(16'h7FFF, 16'h7FFF, 32'hFFFC_0004);
    launch("wrap", 4, 1'b0);
    feed("wrap", 4, -1, 0);

    // K=0: done next cycle, out cleared, in_ready never rises.
    launch("k0", 0, 1'b0);
    check_val("k0_out", |out, 0);
    tick();
    check_val("k0_done_pulse", done, 0);
    check_val("k0_busy_end", busy, 0);
    check_val("k0_ready", in_ready, 0);

    // Reset during LOAD at beat 2, then a clean K=2 job of ones.
    fill(16'h0005, 16'h0005, 32'h0);
    launch("abort", 4, 1'b0);
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      a_col    = {N{16'h0005}};
      b_row    = {N{16'h0005}};
      if (b == 2) rst = 1'b1;
      tick();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    check_val("abort_busy", busy, 0);
    check_val("abort_ready", in_ready, 0);
    check_val("abort_out", |out, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check_val("abort_no_done", done, 0);
    end
    fill(16'h0001, 16'h0001, 32'h2);
    launch("after_rst", 2, 1'b0);
    feed("after_rst", 2, -1, 0);

    // start held high through a job: ignored until back in IDLE.
    fill(16'h0001, 16'h0003, 32'h6);
    launch("held", 2, 1'b1);
    k_len = 8'd9;
    feed("held", 2, -1, 0);
    check_val("held_out_holds", get_c(0, 0), 32'h6);
    check_val("held_idle_ready", in_ready, 0);
    k_len = 8'd2;
    tick();
    check_val("relaunch_busy", busy, 1);
    check_val("relaunch_ready", in_ready, 1);
    check_val("relaunch_clear", get_c(3, 3), 32'h0);
    start = 1'b0;
    feed("relaunch", 2, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
